// File: rtl/dyn_adder_requester.sv
// Initiator-side controller for the 32-bit dynamic (completion-detecting) adder.
// Latency: launch pulse FIRST_CYCLES, then WAIT until the synchronized done (at least SYNC_STAGES cycles), then capture.
// Backpressure: in_ready only in IDLE; the result is held in HOLD (out_valid=1) until out_ready.
//
// Ports: clk/rst_n (async active-low); upstream in_valid/in_ready/in_a/in_b/in_cin;
//        adder side add_a/add_b/add_cin/add_first/add_request out, add_done/add_sum/add_cout in;
//        downstream out_valid/out_ready/out_sum/out_cout/out_latency/out_timeout.
// Optional feature: define DYN_ADDER_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYCLES).
module dyn_adder_requester #(
  parameter int WIDTH          = 32,
  parameter int FIRST_CYCLES   = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int LAT_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             add_first,
  output logic             add_request,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [LAT_W-1:0] out_latency,
  output logic             out_timeout
);

`ifdef DYN_ADDER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int FC_W = (FIRST_CYCLES > 1) ? $clog2(FIRST_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FIRST_LAST = FC_W'(FIRST_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_MAX    = '1;
  localparam logic [LAT_W-1:0] QUAL_MIN   = LAT_W'(SYNC_STAGES);
  localparam logic [LAT_W-1:0] TO_LAST    = LAT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_q;
  logic [FC_W-1:0]        first_cnt;
  logic [LAT_W-1:0]       wait_cnt;
  logic                   accept;
  logic                   capture;
  logic                   qual_done;
  logic                   timeout_hit;

  // add_done is asynchronous to clk; plain shift-register synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], add_done};
    end
  end

  assign done_q = sync_q[SYNC_STAGES-1];

  // The synchronizer still carries the previous op's done for SYNC_STAGES
  // cycles after WAIT entry, so done_q is ignored until it has been flushed.
  assign qual_done   = done_q && (wait_cnt >= QUAL_MIN);
  assign timeout_hit = TIMEOUT_EN && (wait_cnt >= TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    add_first   = 1'b0;
    add_request = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_FIRST;
        end
      end
      S_FIRST: begin
        add_first = 1'b1;
        if (first_cnt == FIRST_LAST) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        add_request = 1'b1;
        if (qual_done || timeout_hit) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters: first_cnt times the launch pulse, wait_cnt measures WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (state == S_FIRST) begin
        first_cnt <= first_cnt + 1'b1;
      end else begin
        first_cnt <= '0;
      end
      if (accept) begin
        wait_cnt <= '0;
      end else if ((state == S_WAIT) && (wait_cnt != LAT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Operand registers feed the adder and stay stable until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (accept) begin
      add_a   <= in_a;
      add_b   <= in_b;
      add_cin <= in_cin;
    end
  end

  // Result registers; a done in the watchdog cycle takes priority, so the
  // timeout flag is set only when the capture was not caused by done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum     <= '0;
      out_cout    <= 1'b0;
      out_latency <= '0;
      out_timeout <= 1'b0;
    end else if (capture) begin
      out_sum     <= add_sum;
      out_cout    <= add_cout;
      out_latency <= wait_cnt;
      out_timeout <= !qual_done;
    end
  end

endmodule

// File: tb/tb_dyn_adder_requester.sv
module tb_dyn_adder_requester;

  localparam int WIDTH = 32;
  localparam int FIRST = 1;
  localparam int SYNC  = 2;
  localparam int LAT_W = 8;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic             add_first;
  logic             add_request;
  logic             add_done = 1'b0;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [LAT_W-1:0] out_latency;
  logic             out_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Adder model controls
  int done_delay = 0;
  bit stale_hold = 1'b0;
  bit never_done = 1'b0;
  int req_cyc    = 0;

  dyn_adder_requester #(
    .WIDTH(WIDTH), .FIRST_CYCLES(FIRST), .SYNC_STAGES(SYNC),
    .LAT_W(LAT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_first(add_first), .add_request(add_request),
    .add_done(add_done), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_latency(out_latency), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural adder: sum is only meaningful while requested and done.
  logic [WIDTH:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_sum  = (add_request && add_done) ? adder_full[WIDTH-1:0] : 32'hDEAD_BEEF;
  assign add_cout = (add_request && add_done) ? adder_full[WIDTH] : 1'b0;

  // done rises done_delay cycles after request rises and falls once request drops.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stale_hold) begin
        add_done = 1'b1;
      end else if (!add_request) begin
        req_cyc  = 0;
        add_done = 1'b0;
      end
      if (add_request) begin
        if (!never_done && req_cyc >= done_delay) add_done = 1'b1;
        req_cyc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: capture happens in WAIT cycle index d+SYNC (done synced),
  // or SYNC when done was already high; watchdog caps it at TO-1.
  function automatic int model_cap(input int d, input bit stale);
    int c;
    c = stale ? SYNC : d + SYNC;
`ifdef DYN_ADDER_TIMEOUT_EN
    if (c > TO - 1) c = TO - 1;
`endif
    return c;
  endfunction

  function automatic bit model_to(input int d, input bit stale);
`ifdef DYN_ADDER_TIMEOUT_EN
    return ((stale ? SYNC : d + SYNC) > TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_lat(input int d, input bit stale);
    int c;
    c = model_cap(d, stale);
    return (c > 255) ? 255 : c;
  endfunction

  // Runs one transaction; caller is #1 after an edge with the DUT idle.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input int d, input bit stale, input int stall,
                        input logic [31:0] exp_sum, input logic exp_cout, input int exp_lat);
    int edges, firsts, exp_edges;
    bit got, a_bad, hold_ok, exp_to;
    logic [31:0] snap_sum;
    exp_to    = model_to(d, stale);
    exp_edges = FIRST + model_cap(d, stale) + 1;
    done_delay = d;
    stale_hold = stale;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    chk({nm, ".in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0; firsts = 0; got = 0; a_bad = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (add_first) firsts++;
      if (add_a !== a) a_bad = 1;
      @(posedge clk); #1;
      edges++;
      if (out_valid) got = 1;
    end
    chk({nm, ".got_valid"}, got, 1);
    if (got) begin
      chk({nm, ".edges"}, edges, exp_edges);
      chk({nm, ".first_cycles"}, firsts, FIRST);
      chk({nm, ".add_a_stable"}, a_bad, 0);
      if (!exp_to) begin
        chk({nm, ".sum"}, out_sum, exp_sum);
        chk({nm, ".cout"}, out_cout, exp_cout);
      end
      chk({nm, ".latency"}, out_latency, exp_lat);
      chk({nm, ".timeout"}, out_timeout, exp_to);
      snap_sum = out_sum;
      hold_ok = 1;
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        in_a = ~a;
        @(posedge clk); #1;
        if (!out_valid || out_sum !== snap_sum || in_ready || add_a !== a) hold_ok = 0;
      end
      if (stall > 0) chk({nm, ".hold_stable"}, hold_ok, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, ".valid_dropped"}, out_valid, 0);
      // A pending in_valid during the handshake edge must not be accepted.
      chk({nm, ".idle_after"}, in_ready, 1);
      in_valid = 1'b0;
    end
    stale_hold = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    int          d;
    bit          stale;
    int          stall;
    logic [31:0] sum;
    logic        cout;
    int          lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [32:0] full;
    int d, lat;
    bit st;
    logic [31:0] ra, rb;
    logic rc;
    bit seen;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0, 0, 32'h0000_0008, 1'b0, 2};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8, 1'b0, 0, 32'h0000_0000, 1'b1, 10};
    tbl[2] = '{32'h0000_000A, 32'h0000_0014, 1'b1, 0, 1'b1, 0, 32'h0000_001F, 1'b0, 2};
    tbl[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 3, 1'b0, 5, 32'h2345_6789, 1'b0, 5};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1, 1'b0, 2, 32'h0000_0001, 1'b1, 3};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 1'b1, 1, 32'hFFFF_FFFF, 1'b1, 2};

    // Reset values
    #3;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.add_first", add_first, 0);
    chk("rst.add_request", add_request, 0);
    chk("rst.out_sum", out_sum, 0);
    chk("rst.out_latency", out_latency, 0);
    chk("rst.add_a", add_a, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].d,
             tbl[i].stale, tbl[i].stall, tbl[i].sum, tbl[i].cout, tbl[i].lat);
    end

    // Randomized transactions against the reference model
    for (int n = 0; n < 25; n++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
`ifdef DYN_ADDER_TIMEOUT_EN
      d = $urandom_range(0, 20);
`else
      d = $urandom_range(0, 12);
`endif
      st = ($urandom_range(0, 3) == 0);
      full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      lat = model_lat(d, st);
      run_op($sformatf("rnd%0d", n), ra, rb, rc, d, st, $urandom_range(0, 3),
             full[31:0], full[32], lat);
    end

`ifndef DYN_ADDER_TIMEOUT_EN
    // Latency counter saturates at 2^LAT_W-1
    run_op("sat", 32'h0000_0100, 32'h0000_0200, 1'b0, 300, 1'b0, 0,
           32'h0000_0300, 1'b0, 255);
`endif

    // Reset asserted mid-WAIT abandons the transaction
    done_delay = 50;
    in_a = 32'h0000_0007; in_b = 32'h0000_0009; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.add_request", add_request, 0);
    chk("midrst.out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || add_request) seen = 1;
    end
    chk("midrst.no_result", seen, 0);

    // add_done never rises
    never_done = 1'b1;
    done_delay = 0;
`ifdef DYN_ADDER_TIMEOUT_EN
    run_op("wdog", 32'h0000_0001, 32'h0000_0002, 1'b0, 1000, 1'b0, 0,
           32'hDEAD_BEEF, 1'b0, TO - 1);
    chk("wdog.sum_forced", out_sum, 32'hDEAD_BEEF);
`else
    in_a = 32'h0000_0001; in_b = 32'h0000_0002; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("nodone.no_valid", seen, 0);
    chk("nodone.still_requesting", add_request, 1);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif
    never_done = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
